// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit: 1-cycle multiply, restoring divide, HI/LO registers.
// Define MDU_HILO_FWD_EN to bypass writes onto hi/lo/done in the cycle they are written.
module mul_div_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIV_STEPS = 32
) (
  input logic           i_clk,
  input logic           i_rst,
  mul_div_unit_if.slave mdu
);
  localparam int unsigned     CntW    = $clog2(DIV_STEPS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DIV_STEPS);
  localparam logic [1:0]      StIdle  = 2'd0;
  localparam logic [1:0]      StMul   = 2'd1;
  localparam logic [1:0]      StDiv   = 2'd2;

  logic [1:0]       r_state;
  logic             r_signed;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_a;    // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0] r_b;    // multiplier, or |divisor|
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CntW-1:0]  r_cnt;

  logic               w_idle;
  logic               w_accept;
  logic               w_fin;
  logic               w_wr_res;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;

  assign w_idle   = (r_state == StIdle);
  assign w_accept = w_idle & mdu.start & ~mdu.flush;
  assign mdu.busy = ~w_idle | w_accept;

  assign w_abs_a = (~mdu.op[0] & mdu.a[WIDTH-1]) ? -mdu.a : mdu.a;
  assign w_abs_b = (~mdu.op[0] & mdu.b[WIDTH-1]) ? -mdu.b : mdu.b;

  // Truncated product of sign/zero-extended operands covers both MULT and MULTU.
  assign w_a_ext = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
  assign w_b_ext = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_shift   = {r_rem, r_a[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_b};
  assign w_quo     = r_neg_q ? -r_a : r_a;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  // A divide by zero parks in StMul and finishes without touching HI/LO.
  assign w_fin    = ~i_rst & ~mdu.flush &
                    ((r_state == StMul) | ((r_state == StDiv) & (r_cnt == LastCnt)));
  assign w_wr_res = w_fin & ~((r_state == StMul) & r_is_div);
  assign w_res_hi = r_is_div ? w_rem_fix : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? w_quo     : w_prod[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_signed <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_idle && mdu.mthi) r_hi <= mdu.wdata;
      if (w_idle && mdu.mtlo) r_lo <= mdu.wdata;
      if (w_wr_res) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end

      if (!w_idle && mdu.flush) begin
        r_state <= StIdle;
      end else begin
        case (r_state)
          StIdle: begin
            if (w_accept) begin
              r_signed <= ~mdu.op[0];
              r_is_div <= mdu.op[1];
              r_neg_q  <= ~mdu.op[0] & (mdu.a[WIDTH-1] ^ mdu.b[WIDTH-1]);
              r_neg_r  <= ~mdu.op[0] & mdu.a[WIDTH-1];
              r_a      <= mdu.op[1] ? w_abs_a : mdu.a;
              r_b      <= mdu.op[1] ? w_abs_b : mdu.b;
              r_rem    <= '0;
              r_cnt    <= '0;
              r_state  <= (mdu.op[1] && (mdu.b != '0)) ? StDiv : StMul;
            end
          end
          StMul: r_state <= StIdle;
          StDiv: begin
            if (r_cnt != LastCnt) begin
              r_cnt <= r_cnt + CntW'(1);
              if (!w_diff[WIDTH]) begin
                r_rem <= w_diff[WIDTH-1:0];
                r_a   <= {r_a[WIDTH-2:0], 1'b1};
              end else begin
                r_rem <= w_shift[WIDTH-1:0];
                r_a   <= {r_a[WIDTH-2:0], 1'b0};
              end
            end else begin
              r_state <= StIdle;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

`ifdef MDU_HILO_FWD_EN
  assign mdu.done = w_fin;
  assign mdu.hi   = w_wr_res ? w_res_hi : ((w_idle & mdu.mthi) ? mdu.wdata : r_hi);
  assign mdu.lo   = w_wr_res ? w_res_lo : ((w_idle & mdu.mtlo) ? mdu.wdata : r_lo);
`else
  logic r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_done <= 1'b0;
    else       r_done <= w_fin;
  end

  assign mdu.done = r_done;
  assign mdu.hi   = r_hi;
  assign mdu.lo   = r_lo;
`endif
endmodule
